// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty-cycle ramp controller: owns the PWM period counter and steps the duty toward a
// requested target only at period boundaries. Optional target clamp: PWM_DUTY_CLAMP_EN.
module pwm_duty_ramp_ctrl #(
    parameter int                  _NUM_BIT    = 12,
    parameter int                  _STEP_BIT   = 8,
    parameter logic [_NUM_BIT-1:0] _RESET_DUTY = '0,
    parameter logic [_NUM_BIT-1:0] _DUTY_MIN   = '0,
    parameter logic [_NUM_BIT-1:0] _DUTY_MAX   = '1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [_NUM_BIT-1:0]  i_target,
    input  logic [_STEP_BIT-1:0] i_step,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [_NUM_BIT-1:0]  o_dutyCycle,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_periodEnd
);

    // Wide enough to hold |tgt - duty| and the step without wrapping.
    localparam int W = ((_NUM_BIT >= _STEP_BIT) ? _NUM_BIT : _STEP_BIT) + 1;

`ifdef PWM_DUTY_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;

    if ((_RESET_DUTY < _DUTY_MIN) || (_RESET_DUTY > _DUTY_MAX)) begin : g_reset_duty_check
        $error("pwm_duty_ramp_ctrl: _RESET_DUTY outside [_DUTY_MIN,_DUTY_MAX]");
    end
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    typedef enum logic [0:0] {IDLE = 1'b0, RAMP = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [_NUM_BIT-1:0]   cnt_q;
    logic [_NUM_BIT-1:0]   duty_q, duty_d;
    logic [_NUM_BIT-1:0]   tgt_q, tgt_d;
    logic [_STEP_BIT-1:0]  stp_q, stp_d;
    logic                  done_q, done_d;
    logic                  ready_q;
    logic                  boundary;
    logic                  xfer;
    logic [W-1:0]          diff_w;
    logic [W-1:0]          stp_w;

    function automatic logic [_NUM_BIT-1:0] clamp_target(input logic [_NUM_BIT-1:0] v);
        logic [_NUM_BIT-1:0] r;
        r = v;
        if (CLAMP_EN) begin
            if (int'(v) < int'(_DUTY_MIN))
                r = _DUTY_MIN;
            else if (int'(v) > int'(_DUTY_MAX))
                r = _DUTY_MAX;
        end
        return r;
    endfunction

    // Only called when the remaining distance exceeds the step, so no overshoot or wrap.
    function automatic logic [_NUM_BIT-1:0] step_toward(input logic [_NUM_BIT-1:0]  cur,
                                                        input logic [_NUM_BIT-1:0]  tgt,
                                                        input logic [_STEP_BIT-1:0] stp);
        logic [W-1:0] cur_w;
        logic [W-1:0] inc_w;
        logic [W-1:0] res_w;
        cur_w = {{(W-_NUM_BIT){1'b0}}, cur};
        inc_w = {{(W-_STEP_BIT){1'b0}}, stp};
        res_w = (tgt > cur) ? (cur_w + inc_w) : (cur_w - inc_w);
        return res_w[_NUM_BIT-1:0];
    endfunction

    assign boundary    = (cnt_q == '1);
    assign xfer        = i_valid && ready_q;
    assign stp_w       = {{(W-_STEP_BIT){1'b0}}, stp_q};
    assign diff_w      = (tgt_q >= duty_q)
                       ? ({{(W-_NUM_BIT){1'b0}}, tgt_q} - {{(W-_NUM_BIT){1'b0}}, duty_q})
                       : ({{(W-_NUM_BIT){1'b0}}, duty_q} - {{(W-_NUM_BIT){1'b0}}, tgt_q});

    assign o_ready     = ready_q;
    assign o_dutyCycle = duty_q;
    assign o_busy      = (state_q == RAMP);
    assign o_done      = done_q;
    assign o_periodEnd = boundary;

    // A request accepted on a boundary edge wins the state, but the boundary step on that
    // same edge still uses the previous target/step.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        stp_d   = stp_q;
        done_d  = 1'b0;
        if ((state_q == RAMP) && boundary) begin
            if ((stp_q == '0) || (diff_w <= stp_w)) begin
                duty_d  = tgt_q;
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                duty_d  = step_toward(duty_q, tgt_q, stp_q);
            end
        end
        if (xfer) begin
            tgt_d   = clamp_target(i_target);
            stp_d   = i_step;
            state_d = RAMP;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            duty_q  <= _RESET_DUTY;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_q + 1'b1;
            duty_q  <= duty_d;
            done_q  <= done_d;
            ready_q <= 1'b1;
        end
    end

    // Request registers are only meaningful in RAMP, so they carry no reset.
    always_ff @(posedge i_clk) begin
        tgt_q <= tgt_d;
        stp_q <= stp_d;
    end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl at _NUM_BIT=4, _STEP_BIT=4 (period 16).
// Honours PWM_DUTY_CLAMP_EN (built with _DUTY_MAX=12).
module tb_pwm_duty_ramp_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [3:0] i_target;
    logic [3:0] i_step;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] o_dutyCycle;
    logic       o_busy;
    logic       o_done;
    logic       o_periodEnd;

    int compared   = 0;
    int mismatched = 0;
    int cnt_m      = 0;
    int done_seen  = 0;

    always #5 i_clk = ~i_clk;

    pwm_duty_ramp_ctrl #(
        ._NUM_BIT   (4),
        ._STEP_BIT  (4),
        ._RESET_DUTY(4'd0),
        ._DUTY_MIN  (4'd0),
        ._DUTY_MAX  (4'd12)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_target   (i_target),
        .i_step     (i_step),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_dutyCycle(o_dutyCycle),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_periodEnd(o_periodEnd)
    );

    always @(negedge i_clk) if (o_done === 1'b1) done_seen++;

    task automatic tick();
        @(posedge i_clk);
        #1;
        cnt_m = (cnt_m + 1) % 16;
    endtask

    task automatic wait_cnt(input int v);
        for (int k = 0; k < 17 && cnt_m != v; k++) tick();
    endtask

    task automatic send(input int t, input int s);
        i_target = 4'(t);
        i_step   = 4'(s);
        i_valid  = 1'b1;
        tick();
        i_valid  = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_target = '0;
        i_step = '0;
        repeat (3) tick();
        cnt_m = 0;
        compared++; if (o_dutyCycle !== 4'd0) begin $display("FAIL reset_duty: got %0d want 0", o_dutyCycle); mismatched++; end
        compared++; if (o_busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", o_busy); mismatched++; end
        compared++; if (o_done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", o_done); mismatched++; end
        compared++; if (o_ready !== 1'b0) begin $display("FAIL reset_ready: got %b want 0", o_ready); mismatched++; end
        i_rst_n = 1'b1;
        compared++; if (o_periodEnd !== 1'b0) begin $display("FAIL reset_cnt0_pend: got %b want 0", o_periodEnd); mismatched++; end
        tick();
        compared++; if (o_ready !== 1'b1) begin $display("FAIL ready_after_reset: got %b want 1", o_ready); mismatched++; end
        wait_cnt(15);
        compared++; if (o_periodEnd !== 1'b1) begin $display("FAIL period_end_at15: got %b want 1", o_periodEnd); mismatched++; end
        tick();
        compared++; if (o_periodEnd !== 1'b0) begin $display("FAIL period_end_at0: got %b want 0", o_periodEnd); mismatched++; end
    endtask

    task automatic test_up_ramp();
        int d0;
        int exp_d[4];
        exp_d = '{3, 6, 9, 10};
        d0 = done_seen;
        wait_cnt(3);
        send(10, 3);
        compared++; if (o_busy !== 1'b1) begin $display("FAIL up_busy: got %b want 1", o_busy); mismatched++; end
        compared++; if (o_dutyCycle !== 4'd0) begin $display("FAIL up_hold: got %0d want 0", o_dutyCycle); mismatched++; end
        for (int i = 0; i < 4; i++) begin
            wait_cnt(0);
            compared++; if (o_dutyCycle !== 4'(exp_d[i])) begin $display("FAIL up_duty%0d: got %0d want %0d", i, o_dutyCycle, exp_d[i]); mismatched++; end
            compared++; if (o_done !== (i == 3)) begin $display("FAIL up_done%0d: got %b want %b", i, o_done, (i == 3)); mismatched++; end
            tick();
        end
        compared++; if (o_busy !== 1'b0) begin $display("FAIL up_busy_end: got %b want 0", o_busy); mismatched++; end
        compared++; if (done_seen - d0 !== 1) begin $display("FAIL up_done_count: got %0d want 1", done_seen - d0); mismatched++; end
    endtask

    task automatic test_down_jump();
        int d0;
        d0 = done_seen;
        wait_cnt(3);
        send(2, 0);
        wait_cnt(0);
        compared++; if (o_dutyCycle !== 4'd2) begin $display("FAIL jump_duty: got %0d want 2", o_dutyCycle); mismatched++; end
        compared++; if (o_done !== 1'b1) begin $display("FAIL jump_done: got %b want 1", o_done); mismatched++; end
        tick();
        compared++; if (o_busy !== 1'b0) begin $display("FAIL jump_busy: got %b want 0", o_busy); mismatched++; end
        compared++; if (done_seen - d0 !== 1) begin $display("FAIL jump_done_count: got %0d want 1", done_seen - d0); mismatched++; end
    endtask

    task automatic test_retarget();
        int d0;
        int exp_d[3];
        exp_d = '{3, 2, 1};
        d0 = done_seen;
        wait_cnt(3);
        send(15, 2);
        wait_cnt(0);
        compared++; if (o_dutyCycle !== 4'd4) begin $display("FAIL rt_first: got %0d want 4", o_dutyCycle); mismatched++; end
        wait_cnt(3);
        send(1, 1);
        for (int i = 0; i < 3; i++) begin
            wait_cnt(0);
            compared++; if (o_dutyCycle !== 4'(exp_d[i])) begin $display("FAIL rt_duty%0d: got %0d want %0d", i, o_dutyCycle, exp_d[i]); mismatched++; end
            compared++; if (o_done !== (i == 2)) begin $display("FAIL rt_done%0d: got %b want %b", i, o_done, (i == 2)); mismatched++; end
            tick();
        end
        compared++; if (done_seen - d0 !== 1) begin $display("FAIL rt_done_count: got %0d want 1", done_seen - d0); mismatched++; end
    endtask

    task automatic test_boundary_xfer();
        int d0;
        d0 = done_seen;
        wait_cnt(15);
        send(5, 0);
        compared++; if (o_dutyCycle !== 4'd1) begin $display("FAIL bnd_hold: got %0d want 1", o_dutyCycle); mismatched++; end
        compared++; if (o_busy !== 1'b1) begin $display("FAIL bnd_busy: got %b want 1", o_busy); mismatched++; end
        compared++; if (o_done !== 1'b0) begin $display("FAIL bnd_nodone: got %b want 0", o_done); mismatched++; end
        tick();
        wait_cnt(0);
        compared++; if (o_dutyCycle !== 4'd5) begin $display("FAIL bnd_duty: got %0d want 5", o_dutyCycle); mismatched++; end
        compared++; if (o_done !== 1'b1) begin $display("FAIL bnd_done: got %b want 1", o_done); mismatched++; end
        tick();
        compared++; if (done_seen - d0 !== 1) begin $display("FAIL bnd_done_count: got %0d want 1", done_seen - d0); mismatched++; end
    endtask

    task automatic test_reset_mid_ramp();
        int d0;
        int bad;
        d0 = done_seen;
        wait_cnt(3);
        send(15, 1);
        wait_cnt(0);
        compared++; if (o_dutyCycle !== 4'd6) begin $display("FAIL mr_step: got %0d want 6", o_dutyCycle); mismatched++; end
        wait_cnt(5);
        i_rst_n = 1'b0;
        tick();
        tick();
        cnt_m = 0;
        compared++; if (o_dutyCycle !== 4'd0) begin $display("FAIL mr_duty: got %0d want 0", o_dutyCycle); mismatched++; end
        compared++; if (o_busy !== 1'b0) begin $display("FAIL mr_busy: got %b want 0", o_busy); mismatched++; end
        i_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_dutyCycle !== 4'd0) bad++;
        end
        compared++; if (bad !== 0) begin $display("FAIL mr_duty_stays: got %0d moving cycles want 0", bad); mismatched++; end
        compared++; if (done_seen - d0 !== 0) begin $display("FAIL mr_no_done: got %0d want 0", done_seen - d0); mismatched++; end
    endtask

    task automatic test_clamp();
        int exp_top;
`ifdef PWM_DUTY_CLAMP_EN
        exp_top = 12;
`else
        exp_top = 15;
`endif
        wait_cnt(3);
        send(15, 5);
        wait_cnt(0);
        compared++; if (o_dutyCycle !== 4'd5) begin $display("FAIL cl_step1: got %0d want 5", o_dutyCycle); mismatched++; end
        tick();
        wait_cnt(0);
        compared++; if (o_dutyCycle !== 4'd10) begin $display("FAIL cl_step2: got %0d want 10", o_dutyCycle); mismatched++; end
        tick();
        wait_cnt(0);
        compared++; if (o_dutyCycle !== 4'(exp_top)) begin $display("FAIL cl_top: got %0d want %0d", o_dutyCycle, exp_top); mismatched++; end
        compared++; if (o_done !== 1'b1) begin $display("FAIL cl_done: got %b want 1", o_done); mismatched++; end
        tick();
        compared++; if (o_busy !== 1'b0) begin $display("FAIL cl_busy: got %b want 0", o_busy); mismatched++; end
    endtask

    initial begin
        test_reset();
        test_up_ramp();
        test_down_jump();
        test_retarget();
        test_boundary_xfer();
        test_reset_mid_ramp();
        test_clamp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
